arm_regfile_sb: RTL and testbench
=================================

// Module: arm_regfile_sb
// PURPOSE
//  Parametrised register file for the multicycle ARM core: NRD combinational read ports, two
//  write ports (A = ALU result, B = memory load), built-in PC increment and a per-register
//  busy scoreboard for outstanding loads. Sits in the datapath between decode/operand fetch
//  and writeback; the control FSM uses rd_busy/sb_ack to stall.
// PARAMETERS
//  DATA_W    32  register width
//  ADDR_W    4   register index width; NREGS = 2**ADDR_W
//  NRD       3   number of read ports (Rn, Rm, Rs)
//  PC_IDX    15  index of the program counter register
//  PC_RESET  0   PC value loaded at reset
//  PC_STEP   4   PC increment per pc_inc
// PORTS
//  clk       in   1             system clock, rising edge
//  reset     in   1             synchronous, active-high reset
//  rd_addr   in   NRD*ADDR_W    read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_data   out  NRD*DATA_W    read data, port k at [k*DATA_W +: DATA_W]
//  rd_busy   out  NRD           port k address is marked busy in scoreboard
//  wa_en     in   1             write port A enable
//  wa_addr   in   ADDR_W        write port A address
//  wa_data   in   DATA_W        write port A data
//  wb_en     in   1             write port B enable (load writeback; clears busy)
//  wb_addr   in   ADDR_W        write port B address
//  wb_data   in   DATA_W        write port B data
//  pc_inc    in   1             PC <= PC + PC_STEP unless PC is written this cycle
//  pc        out  DATA_W        current PC (register PC_IDX)
//  sb_set    in   1             mark sb_addr busy (load issued)
//  sb_addr   in   ADDR_W        scoreboard set address
//  sb_ack    out  1             comb.: sb_set accepted (register not busy, or freed this cycle)
//  wr_clash  out  1             registered: 1 cycle after wa_en&wb_en to the same address
// BEHAVIOUR
//  - Reset (clk edge with reset=1): all registers 0 except PC_IDX = PC_RESET; all busy = 0;
//    wr_clash = 0. reset overrides every other input in that cycle.
//  - Reads: combinational, rd_data[k] = reg[rd_addr[k]] (pre-edge value unless FORWARD_EN).
//  - Writes at rising edge. Same address on A and B: B (load) wins, A dropped, wr_clash=1 next
//    cycle; otherwise wr_clash = 0.
//  - PC: write to PC_IDX via A or B has priority over pc_inc; else pc_inc adds PC_STEP
//    modulo 2**DATA_W (wraps, no flag). pc_inc with no PC write and pc_inc=0: PC holds.
//  - Scoreboard: busy[i] cleared by wb_en with wb_addr=i; set by sb_set&sb_ack with sb_addr=i.
//    Set and clear same register same cycle -> busy stays 1 (new load outstanding).
//    sb_ack = sb_set & (~busy[sb_addr] | (wb_en & wb_addr==sb_addr)). Rejected set: no change.
//  - Port A writes do not touch busy bits. sb_set on PC_IDX is always rejected (sb_ack=0).
//  - rd_busy[k] = busy[rd_addr[k]] (current state; not cleared by same-cycle wb_en unless FORWARD_EN).
// CONFIGURATION
//  ARM_REGFILE_FORWARD_EN defined: write-through bypass. rd_data[k] returns the winning
//    same-cycle write data (B over A) when its address matches rd_addr[k]; rd_busy[k] = 0
//    when wb_en hits the same address. PC forwarding follows the same rule; pc output not bypassed.
//  Undefined: reads see only stored values; one-cycle read-after-write latency.
// STRUCTURE
//  Shared package arm_core_pkg: ARM_PC_IDX, ARM_DATA_W, ARM_ADDR_W, reg_idx_t/word_t typedefs.
//  Sub-module arm_regfile_sb_scoreboard: busy vector, sb_ack, rd_busy (one instance).
//  Storage, write arbitration, PC update and optional bypass stay in the top module.
// TESTING
//  1 reset=1 one edge after random writes -> all rd_data 0, pc=PC_RESET, rd_busy=0, wr_clash=0.
//  2 wa r3=0x11, wb r3=0x22 same edge -> r3=0x22, wr_clash=1 one cycle then 0.
//  3 pc=0xFFFFFFFC, pc_inc -> pc=0; pc_inc with wa r15=0x100 -> pc=0x100.
//  4 sb_set r5 -> sb_ack=1, rd_busy on r5; sb_set r5 again -> sb_ack=0; wb r5=0x7 -> busy clears.
//  5 busy r5, wb r5 and sb_set r5 same cycle -> sb_ack=1, busy stays 1, r5=wb_data.
//  6 FORWARD_EN: wb r2=0xAB, read r2 same cycle -> rd_data=0xAB; without macro -> old value.

Source files
------------

// File: rtl/arm_core_pkg.sv
// Shared ARM core definitions: datapath widths, PC register index and common typedefs.
// Used by arm_regfile_sb and arm_regfile_sb_scoreboard.
package arm_core_pkg;

  localparam int ARM_DATA_W = 32;
  localparam int ARM_ADDR_W = 4;
  localparam int ARM_PC_IDX = 15;

  typedef logic [ARM_ADDR_W-1:0] reg_idx_t;
  typedef logic [ARM_DATA_W-1:0] word_t;

endpackage

// File: rtl/arm_regfile_sb_scoreboard.sv
// Busy scoreboard for outstanding loads: one busy bit per register, set on an accepted
// sb_set and cleared by the port B (load) writeback.
module arm_regfile_sb_scoreboard
  import arm_core_pkg::*;
#(
  parameter int ADDR_W = ARM_ADDR_W,
  parameter int NRD    = 3,
  parameter int PC_IDX = ARM_PC_IDX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic                  sb_ack,
  output logic [NRD-1:0]        rd_busy
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] busy_vec;
  logic             free_now;

  // A load writing back this cycle frees its register for a new load in the same cycle.
  assign free_now = wb_en && (wb_addr == sb_addr);
  assign sb_ack   = sb_set && (sb_addr != ADDR_W'(PC_IDX)) && (!busy_vec[sb_addr] || free_now);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      logic busy_reg;

      // Set beats clear so a re-issued load keeps the register marked outstanding.
      always_ff @(posedge clk) begin
        if (reset) begin
          busy_reg <= 1'b0;
        end else if (sb_ack && (sb_addr == ADDR_W'(gi))) begin
          busy_reg <= 1'b1;
        end else if (wb_en && (wb_addr == ADDR_W'(gi))) begin
          busy_reg <= 1'b0;
        end
      end

      assign busy_vec[gi] = busy_reg;
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd_busy
      assign rd_busy[gi] = busy_vec[rd_addr[gi*ADDR_W +: ADDR_W]];
    end
  endgenerate

endmodule

// File: rtl/arm_regfile_sb.sv
// Multicycle ARM register file: NRD combinational read ports, ALU (A) and load (B) write
// ports, PC increment and load scoreboard. ARM_REGFILE_FORWARD_EN enables write-through bypass.
module arm_regfile_sb
  import arm_core_pkg::*;
#(
  parameter int                DATA_W   = ARM_DATA_W,
  parameter int                ADDR_W   = ARM_ADDR_W,
  parameter int                NRD      = 3,
  parameter int                PC_IDX   = ARM_PC_IDX,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wa_en,
  input  logic [ADDR_W-1:0]     wa_addr,
  input  logic [DATA_W-1:0]     wa_data,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  pc_inc,
  output logic [DATA_W-1:0]     pc,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr,
  output logic                  sb_ack,
  output logic                  wr_clash
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NRD-1:0]    busy_raw;
  logic              wr_clash_reg;
  logic              wr_clash_next;
  logic              wa_take;

  // On an address collision the load result wins and the ALU write is dropped.
  assign wr_clash_next = wa_en && wb_en && (wa_addr == wb_addr);
  assign wa_take       = wa_en && !wr_clash_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_clash_reg <= 1'b0;
    end else begin
      wr_clash_reg <= wr_clash_next;
    end
  end

  assign wr_clash = wr_clash_reg;
  assign pc       = regs_q[PC_IDX];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;
      logic [DATA_W-1:0] q_next;

      // Later assignments take priority: load over ALU over PC increment.
      always_comb begin
        q_next = q_reg;
        if ((gi == PC_IDX) && pc_inc) begin
          q_next = q_reg + DATA_W'(PC_STEP);
        end
        if (wa_take && (wa_addr == ADDR_W'(gi))) begin
          q_next = wa_data;
        end
        if (wb_en && (wb_addr == ADDR_W'(gi))) begin
          q_next = wb_data;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          q_reg <= (gi == PC_IDX) ? PC_RESET : '0;
        end else begin
          q_reg <= q_next;
        end
      end

      assign regs_q[gi] = q_reg;
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

`ifdef ARM_REGFILE_FORWARD_EN
      logic [DATA_W-1:0] rd_word;

      always_comb begin
        rd_word = regs_q[ra];
        if (wa_take && (wa_addr == ra)) begin
          rd_word = wa_data;
        end
        if (wb_en && (wb_addr == ra)) begin
          rd_word = wb_data;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = rd_word;
      assign rd_busy[gi] = busy_raw[gi] && !(wb_en && (wb_addr == ra));
`else
      assign rd_data[gi*DATA_W +: DATA_W] = regs_q[ra];
      assign rd_busy[gi] = busy_raw[gi];
`endif
    end
  endgenerate

  arm_regfile_sb_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .PC_IDX (PC_IDX)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .rd_addr (rd_addr),
    .sb_ack  (sb_ack),
    .rd_busy (busy_raw)
  );

endmodule

// File: tb/tb_arm_regfile_sb.sv
// Self-checking bench for arm_regfile_sb: directed scenarios plus random traffic checked
// against an array-based model of the register file and scoreboard.
module tb_arm_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic        wa_en, wb_en, pc_inc, sb_set;
  logic [3:0]  wa_addr, wb_addr, sb_addr;
  logic [31:0] wa_data, wb_data;
  logic [31:0] pc;
  logic        sb_ack, wr_clash;

  logic [31:0] m_regs [16];
  logic        m_busy [16];
  logic        m_clash;
  int          errors = 0;
  int          checks = 0;
  int          ncyc   = 0;

  always #5 clk = ~clk;

  arm_regfile_sb dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wa_en    (wa_en),
    .wa_addr  (wa_addr),
    .wa_data  (wa_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .pc_inc   (pc_inc),
    .pc       (pc),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_ack   (sb_ack),
    .wr_clash (wr_clash)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; wa_en = 1'b0; wb_en = 1'b0; pc_inc = 1'b0; sb_set = 1'b0;
    wa_addr = 4'd0; wb_addr = 4'd0; sb_addr = 4'd0; wa_data = '0; wb_data = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_clash = 1'b0;
  endtask

  // One clock: check every output against the model, take the edge, advance the model.
  task automatic cyc();
    logic        exp_ack;
    logic [3:0]  a;
    logic [31:0] ed;
    logic        eb;
    #1;
    exp_ack = sb_set && (sb_addr != 4'd15) && (!m_busy[sb_addr] || (wb_en && wb_addr == sb_addr));
    chk("pc", pc, m_regs[15]);
    chk("wr_clash", 32'(wr_clash), 32'(m_clash));
    chk("sb_ack", 32'(sb_ack), 32'(exp_ack));
    for (int k = 0; k < 3; k++) begin
      a  = rd_addr[k*4 +: 4];
      ed = m_regs[a];
      eb = m_busy[a];
`ifdef ARM_REGFILE_FORWARD_EN
      if (wb_en && wb_addr == a) begin
        ed = wb_data;
        eb = 1'b0;
      end else if (wa_en && wa_addr == a) begin
        ed = wa_data;
      end
`endif
      chk($sformatf("rd_data%0d", k), rd_data[k*32 +: 32], ed);
      chk($sformatf("rd_busy%0d", k), 32'(rd_busy[k]), 32'(eb));
    end
    $display("cyc %0d rst=%b wa=%b r%0d=%h wb=%b r%0d=%h inc=%b sb=%b r%0d ack=%b pc=%h",
             ncyc, reset, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, pc_inc,
             sb_set, sb_addr, sb_ack, pc);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (pc_inc) m_regs[15] = m_regs[15] + 32'd4;
      if (wa_en && !(wb_en && wb_addr == wa_addr)) m_regs[wa_addr] = wa_data;
      if (wb_en) begin
        m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (exp_ack) m_busy[sb_addr] = 1'b1;
      m_clash = wa_en && wb_en && (wa_addr == wb_addr);
    end
    ncyc++;
    @(negedge clk);
  endtask

  initial begin
    idle();
    rd_addr = {4'd3, 4'd2, 4'd1};
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    idle();

    // 1: random writes, then reset clears everything
    for (int n = 0; n < 4; n++) begin
      wa_en = 1'b1; wa_addr = 4'(n + 1); wa_data = $urandom;
      wb_en = 1'b1; wb_addr = 4'(n + 8); wb_data = $urandom;
      sb_set = 1'b1; sb_addr = 4'(n + 4); pc_inc = 1'b1;
      cyc();
    end
    idle(); reset = 1'b1;
    cyc();
    idle(); rd_addr = {4'd6, 4'd9, 4'd2};
    #1;
    chk("t1_pc", pc, 32'h0);
    chk("t1_rd", rd_data[31:0] | rd_data[63:32] | rd_data[95:64], 32'h0);
    chk("t1_busy", 32'(rd_busy), 32'h0);
    chk("t1_clash", 32'(wr_clash), 32'h0);

    // 2: A and B collide on r3
    wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'h22;
    cyc();
    idle(); rd_addr = {4'd0, 4'd0, 4'd3};
    #1;
    chk("t2_r3", rd_data[31:0], 32'h22);
    chk("t2_clash1", 32'(wr_clash), 32'h1);
    cyc();
    chk("t2_clash0", 32'(wr_clash), 32'h0);

    // 3: PC wrap and write priority over increment
    wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'hFFFF_FFFC;
    cyc();
    idle(); pc_inc = 1'b1;
    #1;
    chk("t3_pc_pre", pc, 32'hFFFF_FFFC);
    cyc();
    chk("t3_wrap", pc, 32'h0);
    wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'h100; pc_inc = 1'b1;
    cyc();
    chk("t3_pcwr", pc, 32'h100);

    // 4: scoreboard set / reject / clear, PC never accepted
    idle(); rd_addr = {4'd0, 4'd0, 4'd5};
    sb_set = 1'b1; sb_addr = 4'd15;
    #1;
    chk("t4_pc_rej", 32'(sb_ack), 32'h0);
    cyc();
    sb_set = 1'b1; sb_addr = 4'd5;
    #1;
    chk("t4_ack", 32'(sb_ack), 32'h1);
    cyc();
    chk("t4_busy", 32'(rd_busy[0]), 32'h1);
    #1;
    chk("t4_rej", 32'(sb_ack), 32'h0);
    cyc();
    idle(); wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h7;
    cyc();
    idle();
    #1;
    chk("t4_clr", 32'(rd_busy[0]), 32'h0);
    chk("t4_r5", rd_data[31:0], 32'h7);

    // 5: writeback and re-issue on the same register
    sb_set = 1'b1; sb_addr = 4'd5;
    cyc();
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h99;
    #1;
    chk("t5_ack", 32'(sb_ack), 32'h1);
    cyc();
    idle();
    #1;
    chk("t5_busy", 32'(rd_busy[0]), 32'h1);
    chk("t5_r5", rd_data[31:0], 32'h99);

    // 6: same-cycle read of a load target
    wa_en = 1'b1; wa_addr = 4'd2; wa_data = 32'h5;
    cyc();
    idle(); rd_addr = {4'd0, 4'd0, 4'd2};
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'hAB;
    #1;
`ifdef ARM_REGFILE_FORWARD_EN
    chk("t6_fwd", rd_data[31:0], 32'hAB);
`else
    chk("t6_old", rd_data[31:0], 32'h5);
`endif
    cyc();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 59) == 0);
      wa_en   = 1'($urandom_range(0, 1));
      wa_addr = 4'($urandom_range(0, 15));
      wa_data = $urandom;
      wb_en   = ($urandom_range(0, 2) == 0);
      wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : 4'($urandom_range(0, 15));
      wb_data = $urandom;
      pc_inc  = 1'($urandom_range(0, 1));
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = ($urandom_range(0, 1) == 0) ? wb_addr : 4'($urandom_range(0, 15));
      rd_addr = ($urandom_range(0, 1) == 0) ? {wa_addr, sb_addr, wb_addr} : 12'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
